// File: rtl/psg_mix_sequencer.sv
// -----------------------------------------------------------------------------
// psg_mix_sequencer
//
// Time-multiplexed voice mixer and sample-period sequencer for the PSG audio
// path. A free-running divider (gated by en_i) produces the sample count used
// by the output summer and the filter. Once per sample period the block walks
// the voice generators over a shared select/data bus and sums each voice into
// either the filtered or the unfiltered path, according to a routing mask that
// is captured at the start of the scan. When the scan finishes, both sums are
// published together with a one-cycle strobe.
//
// Timeline (cycle k = the cycle in which cnt_o == 1):
//   k .. k+VOICES-1 : SCAN, vsel_o = 0 .. VOICES-1
//   k+VOICES        : LATCH
//   k+VOICES+1      : new ufi_o / fi_o visible, smp_o = 1 (cnt_o == VOICES+2)
//
// Parameters
//   VOICES : voices scanned per sample period (1..4)
//   DIV    : clock cycles per sample period (VOICES+3..256)
//
// Ports
//   clk_i   : master clock, rising edge
//   rst_ni  : asynchronous active-low reset
//   en_i    : run enable, gates the divider counter only
//   fsel_i  : routing mask, bit v = 1 sends voice v to the filtered sum
//   vsel_o  : voice index presented on the shared bus
//   vdat_i  : amplitude of voice vsel_o (combinational from upstream)
//   cnt_o   : sample divider count, 0..DIV-1
//   ufi_o   : unfiltered-path sum of the last completed scan
//   fi_o    : filtered-path sum of the last completed scan
//   smp_o   : one-cycle pulse when ufi_o / fi_o take new values
//   busy_o  : high while a scan is in progress (SCAN or LATCH)
// -----------------------------------------------------------------------------
module psg_mix_sequencer #(
  parameter int VOICES = 4,
  parameter int DIV    = 256
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              en_i,
  input  logic [VOICES-1:0] fsel_i,
  output logic [1:0]        vsel_o,
  input  logic [19:0]       vdat_i,
  output logic [7:0]        cnt_o,
  output logic [21:0]       ufi_o,
  output logic [21:0]       fi_o,
  output logic              smp_o,
  output logic              busy_o
);

  localparam logic [7:0] CNT_LAST  = 8'(DIV - 1);
  localparam logic [1:0] VIDX_LAST = 2'(VOICES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_LATCH = 2'd2
  } state_e;

  state_e      state_q, state_d;

  logic [7:0]  cnt_q,   cnt_d;
  logic [1:0]  vidx_q,  vidx_d;
  logic [21:0] acc_u_q, acc_u_d;
  logic [21:0] acc_f_q, acc_f_d;
  logic [3:0]  fmask_q, fmask_d;
  logic [21:0] ufi_q,   ufi_d;
  logic [21:0] fi_q,    fi_d;
  logic        smp_q,   smp_d;

  logic [3:0]  fsel_ext;
  logic        scan_start;
  logic        route_f;
  logic [21:0] vdat_ext;

  // Widen the routing mask to the full 4-voice bus so it can be indexed by
  // the 2-bit voice index regardless of VOICES; unused voices read as 0.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_fsel_ext
      if (gi < VOICES) begin : g_used
        assign fsel_ext[gi] = fsel_i[gi];
      end else begin : g_unused
        assign fsel_ext[gi] = 1'b0;
      end
    end
  endgenerate

  // The counter only ever reaches 1 from 0, so entering SCAN on the same edge
  // makes the cycle with cnt_o == 1 the first scan cycle (voice 0).
  assign scan_start = en_i && (cnt_q == 8'd0);

  // Voice 0 is scanned in the cnt_o == 1 cycle, the very cycle the mask is
  // captured, so it routes on the live fsel_i; later voices use the snapshot.
  assign route_f  = (vidx_q == 2'd0) ? fsel_ext[0] : fmask_q[vidx_q];
  assign vdat_ext = {2'b00, vdat_i};

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (scan_start) begin
          state_d = ST_SCAN;
        end
      end
      ST_SCAN: begin
        // Scan runs to completion even if en_i drops; only the counter stops.
        if (vidx_q == VIDX_LAST) begin
          state_d = ST_LATCH;
        end
      end
      ST_LATCH: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    vsel_o = 2'd0;
    busy_o = 1'b0;
    case (state_q)
      ST_SCAN: begin
        vsel_o = vidx_q;
        busy_o = 1'b1;
      end
      ST_LATCH: begin
        busy_o = 1'b1;
      end
      default: begin
        vsel_o = 2'd0;
        busy_o = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: divider, accumulators, mask snapshot, published sums
  // ---------------------------------------------------------------------------
  always_comb begin
    cnt_d   = cnt_q;
    vidx_d  = vidx_q;
    acc_u_d = acc_u_q;
    acc_f_d = acc_f_q;
    fmask_d = fmask_q;
    ufi_d   = ufi_q;
    fi_d    = fi_q;
    smp_d   = 1'b0;

    if (en_i) begin
      cnt_d = (cnt_q == CNT_LAST) ? 8'd0 : cnt_q + 8'd1;
    end

    case (state_q)
      ST_IDLE: begin
        if (scan_start) begin
          vidx_d  = 2'd0;
          acc_u_d = 22'd0;
          acc_f_d = 22'd0;
        end
      end
      ST_SCAN: begin
        if (vidx_q == 2'd0) begin
          fmask_d = fsel_ext;
        end
        // Four 20-bit voices cannot exceed 22 bits, so no saturation needed.
        if (route_f) begin
          acc_f_d = acc_f_q + vdat_ext;
        end else begin
          acc_u_d = acc_u_q + vdat_ext;
        end
        vidx_d = vidx_q + 2'd1;
      end
      ST_LATCH: begin
        ufi_d = acc_u_q;
        fi_d  = acc_f_q;
        smp_d = 1'b1;
      end
      default: begin
        smp_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q   <= 8'd0;
      vidx_q  <= 2'd0;
      acc_u_q <= 22'd0;
      acc_f_q <= 22'd0;
      fmask_q <= 4'd0;
      ufi_q   <= 22'd0;
      fi_q    <= 22'd0;
      smp_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      vidx_q  <= vidx_d;
      acc_u_q <= acc_u_d;
      acc_f_q <= acc_f_d;
      fmask_q <= fmask_d;
      ufi_q   <= ufi_d;
      fi_q    <= fi_d;
      smp_q   <= smp_d;
    end
  end

  assign cnt_o = cnt_q;
  assign ufi_o = ufi_q;
  assign fi_o  = fi_q;
  assign smp_o = smp_q;

endmodule

// File: tb/tb_psg_mix_sequencer.sv
// -----------------------------------------------------------------------------
// tb_psg_mix_sequencer
//
// Directed bench for psg_mix_sequencer. One instance uses VOICES=4, DIV=256;
// a second instance uses VOICES=1, DIV=4. Voice amplitudes come from a small
// lookup table indexed by vsel. All expected values are hand-computed.
// -----------------------------------------------------------------------------
module tb_psg_mix_sequencer;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance (VOICES=4, DIV=256)
  logic        rst_n;
  logic        en;
  logic [3:0]  fsel;
  logic [1:0]  vsel;
  logic [19:0] vdat;
  logic [7:0]  cnt;
  logic [21:0] ufi;
  logic [21:0] fi;
  logic        smp;
  logic        busy;
  logic [19:0] vtab [4];

  always_comb vdat = vtab[vsel];

  psg_mix_sequencer #(.VOICES(4), .DIV(256)) u_dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .en_i   (en),
    .fsel_i (fsel),
    .vsel_o (vsel),
    .vdat_i (vdat),
    .cnt_o  (cnt),
    .ufi_o  (ufi),
    .fi_o   (fi),
    .smp_o  (smp),
    .busy_o (busy)
  );

  // Small instance (VOICES=1, DIV=4)
  logic        rst1_n;
  logic        en1;
  logic [0:0]  fsel1;
  logic [1:0]  vsel1;
  logic [19:0] vdat1;
  logic [7:0]  cnt1;
  logic [21:0] ufi1;
  logic [21:0] fi1;
  logic        smp1;
  logic        busy1;

  psg_mix_sequencer #(.VOICES(1), .DIV(4)) u_dut1 (
    .clk_i  (clk),
    .rst_ni (rst1_n),
    .en_i   (en1),
    .fsel_i (fsel1),
    .vsel_o (vsel1),
    .vdat_i (vdat1),
    .cnt_o  (cnt1),
    .ufi_o  (ufi1),
    .fi_o   (fi1),
    .smp_o  (smp1),
    .busy_o (busy1)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
      $display("check %-14s ok   value=%0d", tag, got);
    end else begin
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock and settle past the edge before sampling/driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Step until smp is high; n = number of ticks taken.
  task automatic wait_smp(input int max_cyc, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!smp && n < max_cyc);
    if (!smp) check("smp_timeout", 32'(smp), 32'd1);
  endtask

  // Step until cnt equals target.
  task automatic wait_cnt(input logic [7:0] target, input int max_cyc);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (cnt != target && n < max_cyc);
    if (cnt != target) check("cnt_timeout", 32'(cnt), 32'(target));
  endtask

  initial begin
    int n;
    int pulses;

    rst_n = 1'b0;
    en    = 1'b1;
    fsel  = 4'b0101;
    vtab[0] = 20'd100;
    vtab[1] = 20'd200;
    vtab[2] = 20'd300;
    vtab[3] = 20'd400;
    rst1_n = 1'b0;
    en1    = 1'b1;
    fsel1  = 1'b1;
    vdat1  = 20'd77;

    // ---- reset state ----
    tick();
    tick();
    check("rst_cnt",  32'(cnt),  32'd0);
    check("rst_ufi",  32'(ufi),  32'd0);
    check("rst_fi",   32'(fi),   32'd0);
    check("rst_smp",  32'(smp),  32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_vsel", 32'(vsel), 32'd0);

    // ---- first scan after reset release ----
    rst_n = 1'b1;
    tick();
    check("k_cnt",    32'(cnt),  32'd1);
    check("k_busy",   32'(busy), 32'd1);
    check("k_vsel0",  32'(vsel), 32'd0);
    tick();
    check("k_vsel1",  32'(vsel), 32'd1);
    tick();
    check("k_vsel2",  32'(vsel), 32'd2);
    tick();
    check("k_vsel3",  32'(vsel), 32'd3);
    tick();
    check("latch_cnt",  32'(cnt),  32'd5);
    check("latch_busy", 32'(busy), 32'd1);
    check("latch_smp",  32'(smp),  32'd0);
    tick();
    check("pub_smp",  32'(smp),  32'd1);
    check("pub_cnt",  32'(cnt),  32'd6);
    check("pub_fi",   32'(fi),   32'd400);
    check("pub_ufi",  32'(ufi),  32'd600);
    check("pub_busy", 32'(busy), 32'd0);
    tick();
    check("smp_1cyc", 32'(smp),  32'd0);
    wait_smp(300, n);
    // one tick was already spent on the strobe-width check
    check("period",   32'(n + 1), 32'd256);
    check("per_cnt",  32'(cnt),   32'd6);

    // ---- maximum values, no wrap ----
    vtab[0] = 20'hFFFFF;
    vtab[1] = 20'hFFFFF;
    vtab[2] = 20'hFFFFF;
    vtab[3] = 20'hFFFFF;
    fsel = 4'b1111;
    wait_smp(300, n);
    check("max_fi",   32'(fi),  32'd4194300);
    check("max_ufi",  32'(ufi), 32'd0);
    fsel = 4'b0000;
    wait_smp(300, n);
    check("max_ufi2", 32'(ufi), 32'd4194300);
    check("max_fi2",  32'(fi),  32'd0);

    // ---- routing snapshot: fsel change at k+2 has no effect this period ----
    vtab[0] = 20'd1;
    vtab[1] = 20'd2;
    vtab[2] = 20'd3;
    vtab[3] = 20'd4;
    wait_cnt(8'd1, 300);
    tick();
    tick();
    fsel = 4'b1111;
    wait_smp(300, n);
    check("snap_ufi", 32'(ufi), 32'd10);
    check("snap_fi",  32'(fi),  32'd0);
    wait_smp(300, n);
    check("snap_fi2", 32'(fi),  32'd10);
    check("snap_ufi2",32'(ufi), 32'd0);

    // ---- enable dropped at k+1 ----
    vtab[0] = 20'd10;
    vtab[1] = 20'd20;
    vtab[2] = 20'd30;
    vtab[3] = 20'd40;
    wait_cnt(8'd1, 300);
    tick();
    en = 1'b0;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (smp) pulses++;
    end
    check("en_scan_once", 32'(pulses), 32'd1);
    check("en_cnt_frz",   32'(cnt),    32'd2);
    check("en_fi",        32'(fi),     32'd100);
    pulses = 0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (smp) pulses++;
    end
    check("en_low_nosmp", 32'(pulses), 32'd0);
    check("en_low_cnt",   32'(cnt),    32'd2);
    check("en_low_fi",    32'(fi),     32'd100);
    en = 1'b1;
    wait_smp(400, n);
    check("resume_lat",   32'(n),   32'd260);
    check("resume_cnt",   32'(cnt), 32'd6);

    // ---- publish nonzero in both paths, then reset mid-scan ----
    vtab[0] = 20'd5;
    vtab[1] = 20'd6;
    vtab[2] = 20'd7;
    vtab[3] = 20'd8;
    fsel = 4'b0011;
    wait_smp(300, n);
    check("pre_fi",  32'(fi),  32'd11);
    check("pre_ufi", 32'(ufi), 32'd15);
    wait_cnt(8'd1, 300);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("mrst_cnt",  32'(cnt),  32'd0);
    check("mrst_vsel", 32'(vsel), 32'd0);
    check("mrst_ufi",  32'(ufi),  32'd0);
    check("mrst_fi",   32'(fi),   32'd0);
    check("mrst_smp",  32'(smp),  32'd0);
    check("mrst_busy", 32'(busy), 32'd0);
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (smp) pulses++;
    end
    check("mrst_nosmp", 32'(pulses), 32'd0);
    rst_n = 1'b1;
    wait_smp(20, n);
    check("mrst_lat", 32'(n),   32'd6);
    check("mrst_pcnt",32'(cnt), 32'd6);
    check("mrst_fi",  32'(fi),  32'd11);
    check("mrst_ufi", 32'(ufi), 32'd15);

    // ---- VOICES=1, DIV=4 instance ----
    rst1_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      check("v1_vsel", 32'(vsel1), 32'd0);
      if (smp1) begin
        pulses++;
        check("v1_cnt", 32'(cnt1), 32'd3);
        check("v1_fi",  32'(fi1),  32'd77);
        check("v1_ufi", 32'(ufi1), 32'd0);
      end
    end
    check("v1_pulses", 32'(pulses), 32'd4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
